// File: rtl/multi_street_tlc.sv
// ---------------------------------------------------------------------------
// multi_street_tlc
// Parametrised N-street traffic light controller. One street at a time owns
// the green/yellow/all-red phase; waiting streets are served round-robin and
// an emergency request can preempt the current green.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   traffic      in   [NUM_STREETS] vehicle-present per street
//   emg_req      in   emergency preemption request (level)
//   emg_street   in   [IDX_W] street requested by emergency (>= NUM_STREETS ignored)
//   lights       out  [NUM_STREETS] colors, registered
//   active       out  [IDX_W] street owning the current phase
//   next_street  out  [IDX_W] street latched for the next green
//
// state   | meaning
// --------+--------------------------------------------------------------
// GREEN   | active street green, all others red
// YELLOW  | active street yellow for YELLOW_CYC cycles
// ALLRED  | every street red for ALL_RED_CYC cycles, then next_street green
// ---------------------------------------------------------------------------

package light_package;
  typedef enum logic [1:0] {
    green  = 2'd0,
    yellow = 2'd1,
    red    = 2'd2
  } colors;
endpackage

module multi_street_tlc
  import light_package::*;
#(
  parameter int NUM_STREETS = 3,
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 8,
  parameter int YELLOW_CYC  = 2,
  parameter int ALL_RED_CYC = 1,
  parameter int IDX_W       = $clog2(NUM_STREETS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_STREETS-1:0]  traffic,
  input  logic                    emg_req,
  input  logic [IDX_W-1:0]        emg_street,
  output colors [NUM_STREETS-1:0] lights,
  output logic [IDX_W-1:0]        active,
  output logic [IDX_W-1:0]        next_street
);

  localparam logic [1:0] ST_GREEN  = 2'd0;
  localparam logic [1:0] ST_YELLOW = 2'd1;
  localparam logic [1:0] ST_ALLRED = 2'd2;

  // The timer must be able to reach the longest interval it is compared to.
  localparam int TMR_LIM_I = (GREEN_MAX >= YELLOW_CYC && GREEN_MAX >= ALL_RED_CYC) ? GREEN_MAX :
                             (YELLOW_CYC >= ALL_RED_CYC) ? YELLOW_CYC : ALL_RED_CYC;
  localparam int TMR_W     = $clog2(TMR_LIM_I + 1);

  localparam logic [TMR_W-1:0] TMR_LIM    = TMR_W'(TMR_LIM_I);
  // tmr counts edges since state entry, so the state has been displayed for
  // tmr+1 cycles when an edge is evaluated; compare against interval-1.
  localparam logic [TMR_W-1:0] GMIN_LAST  = TMR_W'(GREEN_MIN - 1);
  localparam logic [TMR_W-1:0] GMAX_LAST  = TMR_W'(GREEN_MAX - 1);
  localparam logic [TMR_W-1:0] YEL_LAST   = TMR_W'(YELLOW_CYC - 1);
  localparam logic [TMR_W-1:0] AR_LAST    = TMR_W'(ALL_RED_CYC - 1);

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       active_q, active_d;
  logic [IDX_W-1:0]       next_q, next_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  colors [NUM_STREETS-1:0] lights_q, lights_d;

  logic                   emg_valid;
  logic [NUM_STREETS-1:0] self_mask;
  logic                   other_waiting;
  logic                   min_exit;
  logic                   max_exit;

  // First requesting street after cur, wrapping; cur is returned if none.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_STREETS-1:0] req,
                                               input logic [IDX_W-1:0]       cur);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic             found;
    int               sum;
    pick  = cur;
    found = 1'b0;
    for (int k = 1; k < NUM_STREETS; k++) begin
      sum = int'(cur) + k;
      if (sum >= NUM_STREETS) sum = sum - NUM_STREETS;
      idx = IDX_W'(sum);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    emg_valid = emg_req && (int'(emg_street) < NUM_STREETS);

    self_mask           = '0;
    self_mask[active_q] = 1'b1;
    other_waiting       = |(traffic & ~self_mask);

    min_exit = (tmr_q >= GMIN_LAST) && !traffic[active_q];
    max_exit = (tmr_q >= GMAX_LAST);
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    next_d   = next_q;
    tmr_d    = (tmr_q == TMR_LIM) ? tmr_q : tmr_q + 1'b1;

    case (state_q)
      ST_GREEN: begin
        next_d = active_q;
        if (emg_valid) begin
          // Emergency for the green street holds it; any other street preempts.
          if (emg_street != active_q) begin
            state_d = ST_YELLOW;
            next_d  = emg_street;
          end
        end else if (other_waiting && (min_exit || max_exit)) begin
          state_d = ST_YELLOW;
          next_d  = rr_pick(traffic, active_q);
        end
      end

      ST_YELLOW: begin
        if (emg_valid) next_d = emg_street;
        if (tmr_q >= YEL_LAST) state_d = ST_ALLRED;
      end

      ST_ALLRED: begin
        if (emg_valid) next_d = emg_street;
        if (tmr_q >= AR_LAST) begin
          state_d  = ST_GREEN;
          active_d = next_d;
        end
      end

      default: begin
        state_d  = ST_GREEN;
        active_d = '0;
        next_d   = '0;
      end
    endcase

    if (state_d != state_q) tmr_d = '0;

    // Lights are derived from the next state so they register with it.
    for (int i = 0; i < NUM_STREETS; i++) lights_d[i] = red;
    if (state_d == ST_GREEN)       lights_d[active_d] = green;
    else if (state_d == ST_YELLOW) lights_d[active_d] = yellow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_GREEN;
      active_q <= '0;
      next_q   <= '0;
      tmr_q    <= '0;
      for (int i = 0; i < NUM_STREETS; i++) lights_q[i] <= (i == 0) ? green : red;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      next_q   <= next_d;
      tmr_q    <= tmr_d;
      lights_q <= lights_d;
    end
  end

  assign lights      = lights_q;
  assign active      = active_q;
  assign next_street = next_q;

endmodule
